// File: rtl/ff_adc_ctrl.sv
// Food Fight analog-input conversion controller: single conversion per START,
// or a free-running four-channel scan when FF_ADC_AUTOSCAN_EN is defined.
module ff_adc_ctrl #(
  parameter int CONV_CYCLES = 4800,
  parameter int CW          = 16
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [7:0] AX0,
  input  logic [7:0] AY0,
  input  logic [7:0] AX1,
  input  logic [7:0] AY1,
  input  logic [1:0] CH,
  input  logic       START,
  output logic [7:0] DOUT,
  output logic       BUSY,
  output logic       EOC,
  output logic       EOC_P
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

  logic [7:0] chan [4];

  assign chan[0] = AX0;
  assign chan[1] = AY0;
  assign chan[2] = AX1;
  assign chan[3] = AY1;

`ifdef FF_ADC_AUTOSCAN_EN

  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [7:0]    bank [4];
  logic          eoc_q;
  logic          eoc_p_q;
  logic          unused_start;

  assign unused_start = START;

  // Each slot lasts CONV_CYCLES edges; the write happens on the slot's last edge.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      ptr     <= 2'd0;
      cnt     <= CNT_LOAD;
      eoc_q   <= 1'b0;
      eoc_p_q <= 1'b0;
      for (int i = 0; i < 4; i++) bank[i] <= 8'h80;
    end else begin
      eoc_p_q <= 1'b0;
      if (cnt == '0) begin
        bank[ptr] <= chan[ptr];
        eoc_p_q   <= 1'b1;
        cnt       <= CNT_LOAD;
        ptr       <= ptr + 2'd1;
        if (ptr == 2'd3) eoc_q <= 1'b1;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  assign DOUT  = bank[CH];
  assign BUSY  = 1'b0;
  assign EOC   = eoc_q;
  assign EOC_P = eoc_p_q;

`else

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [7:0]    hold;
  logic [7:0]    dout_q;
  logic          eoc_q;
  logic          eoc_p_q;

  // START is honoured in any state, so a restart on the terminal cycle beats completion.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hold    <= 8'h80;
      dout_q  <= 8'h80;
      eoc_q   <= 1'b1;
      eoc_p_q <= 1'b0;
    end else begin
      eoc_p_q <= 1'b0;
      if (START) begin
        hold  <= chan[CH];
        cnt   <= CNT_LOAD;
        eoc_q <= 1'b0;
        state <= ST_CONV;
      end else if (state == ST_CONV) begin
        if (cnt != '0) begin
          cnt <= cnt - CW'(1);
        end else begin
          dout_q  <= hold;
          eoc_q   <= 1'b1;
          eoc_p_q <= 1'b1;
          state   <= ST_IDLE;
        end
      end
    end
  end

  assign DOUT  = dout_q;
  assign BUSY  = (state == ST_CONV);
  assign EOC   = eoc_q;
  assign EOC_P = eoc_p_q;

`endif

endmodule

// File: tb/tb_ff_adc_ctrl.sv
// Self-checking bench for ff_adc_ctrl: three instances (4800, 1 and 4 cycle
// conversions) share stimulus and are compared every cycle to a deadline-based model.
module tb_ff_adc_ctrl;

  localparam int C0 = 4800;
  localparam int C1 = 1;
  localparam int C2 = 4;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic [7:0] ax0, ay0, ax1, ay1;
  logic [1:0] ch;
  logic       start;
  logic [7:0] dout  [3];
  logic       busy  [3];
  logic       eoc   [3];
  logic       eoc_p [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 MCLK = ~MCLK;

  ff_adc_ctrl #(.CONV_CYCLES(C0), .CW(16)) dut0 (
    .MCLK(MCLK), .RESET(RESET), .AX0(ax0), .AY0(ay0), .AX1(ax1), .AY1(ay1),
    .CH(ch), .START(start), .DOUT(dout[0]), .BUSY(busy[0]), .EOC(eoc[0]), .EOC_P(eoc_p[0]));
  ff_adc_ctrl #(.CONV_CYCLES(C1), .CW(16)) dut1 (
    .MCLK(MCLK), .RESET(RESET), .AX0(ax0), .AY0(ay0), .AX1(ax1), .AY1(ay1),
    .CH(ch), .START(start), .DOUT(dout[1]), .BUSY(busy[1]), .EOC(eoc[1]), .EOC_P(eoc_p[1]));
  ff_adc_ctrl #(.CONV_CYCLES(C2), .CW(3)) dut2 (
    .MCLK(MCLK), .RESET(RESET), .AX0(ax0), .AY0(ay0), .AX1(ax1), .AY1(ay1),
    .CH(ch), .START(start), .DOUT(dout[2]), .BUSY(busy[2]), .EOC(eoc[2]), .EOC_P(eoc_p[2]));

  // Reference model: a conversion is a pending value with an absolute due edge.
  longint unsigned cyc;
  bit              pend  [3];
  longint unsigned due   [3];
  logic [7:0]      mval  [3];
  logic [7:0]      mdout [3];
  logic [7:0]      mbank [3][4];
  bit              meoc  [3];
  bit              meocp [3];

  function automatic int cc(input int i);
    return (i == 0) ? C0 : (i == 1) ? C1 : C2;
  endfunction

  function automatic logic [7:0] chan(input int c);
    case (c)
      0:       return ax0;
      1:       return ay0;
      2:       return ax1;
      default: return ay1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      pend[i]  = 1'b0;
      mdout[i] = 8'h80;
`ifdef FF_ADC_AUTOSCAN_EN
      meoc[i]  = 1'b0;
`else
      meoc[i]  = 1'b1;
`endif
      meocp[i] = 1'b0;
      for (int k = 0; k < 4; k++) mbank[i][k] = 8'h80;
    end
  endtask

  task automatic model_edge();
    if (RESET) begin
      model_reset();
      return;
    end
    cyc++;
    for (int i = 0; i < 3; i++) begin
`ifdef FF_ADC_AUTOSCAN_EN
      meocp[i] = (cyc % longint'(cc(i)) == 0);
      if (meocp[i]) begin
        longint unsigned slot = cyc / longint'(cc(i));
        int p = int'((slot - 1) % 4);
        mbank[i][p] = chan(p);
        if (slot >= 4) meoc[i] = 1'b1;
      end
`else
      meocp[i] = 1'b0;
      if (start) begin
        pend[i] = 1'b1;
        due[i]  = cyc + longint'(cc(i));
        mval[i] = chan(int'(ch));
        meoc[i] = 1'b0;
      end else if (pend[i] && cyc == due[i]) begin
        mdout[i] = mval[i];
        meoc[i]  = 1'b1;
        meocp[i] = 1'b1;
        pend[i]  = 1'b0;
      end
`endif
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
`ifdef FF_ADC_AUTOSCAN_EN
      chk($sformatf("m%0d dout", i), dout[i], mbank[i][ch]);
      chk($sformatf("m%0d busy", i), busy[i], 0);
`else
      chk($sformatf("m%0d dout", i), dout[i], mdout[i]);
      chk($sformatf("m%0d busy", i), busy[i], pend[i]);
`endif
      chk($sformatf("m%0d eoc", i), eoc[i], meoc[i]);
      chk($sformatf("m%0d eoc_p", i), eoc_p[i], meocp[i]);
    end
  endtask

  task automatic cycle();
    @(posedge MCLK);
    model_edge();
    @(negedge MCLK);
    check_all();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    model_reset();
    repeat (3) cycle();
    RESET = 1'b0;
  endtask

`ifndef FF_ADC_AUTOSCAN_EN
  typedef struct {
    bit         st;
    logic [1:0] c;
    logic [7:0] d;
    bit         b;
    bit         e;
    bit         p;
  } vec_t;

  vec_t tbl [8];

  task automatic run_table();
    tbl[0] = '{1'b1, 2'd1, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 2'd2, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd3, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 2'd0, 8'h99, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 2'd0, 8'h99, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 2'd0, 8'h10, 1'b0, 1'b1, 1'b1};
    ax0 = 8'h10; ay0 = 8'h3C; ax1 = 8'h11; ay1 = 8'h99;
    for (int r = 0; r < 8; r++) begin
      start = tbl[r].st;
      ch    = tbl[r].c;
      cycle();
      chk($sformatf("tbl%0d dout", r), dout[1], tbl[r].d);
      chk($sformatf("tbl%0d busy", r), busy[1], tbl[r].b);
      chk($sformatf("tbl%0d eoc", r), eoc[1], tbl[r].e);
      chk($sformatf("tbl%0d eoc_p", r), eoc_p[1], tbl[r].p);
    end
    start = 1'b0;
  endtask

  task automatic run_directed();
    bit seen_p;
    do_reset();
    chk("idle dout", dout[0], 8'h80);
    chk("idle eoc", eoc[0], 1);
    chk("idle busy", busy[0], 0);
    chk("idle eoc_p", eoc_p[0], 0);

    // Single conversion of AY0 with a mid-conversion input change.
    ay0 = 8'h3C; ch = 2'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("conv busy@k", busy[0], 1);
    chk("conv eoc@k", eoc[0], 0);
    seen_p = 1'b0;
    for (int j = 1; j < C0; j++) begin
      if (j == 10) ay0 = 8'hFF;
      cycle();
      if (eoc_p[0] || !busy[0]) seen_p = 1'b1;
    end
    chk("conv early done", seen_p, 0);
    chk("conv dout@k+4799", dout[0], 8'h80);
    cycle();
    chk("conv dout@k+4800", dout[0], 8'h3C);
    chk("conv eoc@k+4800", eoc[0], 1);
    chk("conv eoc_p@k+4800", eoc_p[0], 1);
    chk("conv busy@k+4800", busy[0], 0);
    cycle();
    chk("conv eoc_p@k+4801", eoc_p[0], 0);
    chk("conv eoc hold", eoc[0], 1);

    // Restart mid-conversion.
    ax1 = 8'h11; ay1 = 8'h99; ch = 2'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    seen_p = 1'b0;
    for (int j = 1; j <= C0 + 100; j++) begin
      start = (j == 100);
      if (j == 100) ch = 2'd3;
      cycle();
      start = 1'b0;
      if (j < C0 + 100 && eoc_p[0]) seen_p = 1'b1;
      if (j == C0) begin
        chk("rst dout@k+4800", dout[0], 8'h3C);
        chk("rst busy@k+4800", busy[0], 1);
      end
      if (j == C0 + 99) chk("rst dout@k+4899", dout[0], 8'h3C);
    end
    chk("rst no early eoc_p", seen_p, 0);
    chk("rst dout@k+4900", dout[0], 8'h99);
    chk("rst eoc_p@k+4900", eoc_p[0], 1);

    // Reset in the middle of a conversion.
    ch = 2'd0; ax0 = 8'h5A; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int j = 1; j < 2000; j++) cycle();
    RESET = 1'b1;
    #1;
    model_reset();
    chk("abort dout", dout[0], 8'h80);
    chk("abort busy", busy[0], 0);
    chk("abort eoc", eoc[0], 1);
    cycle();
    RESET = 1'b0;
    seen_p = 1'b0;
    for (int j = 0; j < 3000; j++) begin
      cycle();
      if (eoc_p[0]) seen_p = 1'b1;
    end
    chk("abort no eoc_p", seen_p, 0);
    chk("abort dout after", dout[0], 8'h80);

    // Back-to-back starts keep the block busy.
    seen_p = 1'b0;
    start = 1'b1;
    for (int j = 0; j < 20; j++) begin
      ch = 2'(j);
      cycle();
      if (!busy[1] || eoc[1]) seen_p = 1'b1;
    end
    start = 1'b0;
    chk("b2b busy/eoc", seen_p, 0);
  endtask
`else
  task automatic run_autoscan();
    do_reset();
    ax0 = 8'h10; ay0 = 8'h20; ax1 = 8'h30; ay1 = 8'h40;
    ch = 2'd0;
    for (int n = 1; n <= 16; n++) begin
      start = 1'($urandom);
      cycle();
      chk($sformatf("scan eoc@%0d", n), eoc[2], (n >= 16) ? 1 : 0);
      chk($sformatf("scan eoc_p@%0d", n), eoc_p[2], (n % 4 == 0) ? 1 : 0);
      chk($sformatf("scan busy@%0d", n), busy[2], 0);
    end
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ch = 2'(c);
      #1;
      chk($sformatf("scan dout ch%0d", c), dout[2], 16 * (c + 1));
    end
  endtask
`endif

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    ch    = 2'd0;
    ax0 = 8'h00; ay0 = 8'h00; ax1 = 8'h00; ay1 = 8'h00;
    do_reset();
`ifdef FF_ADC_AUTOSCAN_EN
    run_autoscan();
`else
    run_table();
    run_directed();
`endif
    for (int n = 0; n < 3000; n++) begin
      ax0   = 8'($urandom);
      ay0   = 8'($urandom);
      ax1   = 8'($urandom);
      ay1   = 8'($urandom);
      ch    = 2'($urandom);
      start = ($urandom_range(0, 7) == 0);
      RESET = ($urandom_range(0, 699) == 0);
      cycle();
    end
    RESET = 1'b0;
    start = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
